// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encodings and the packed flag layout.
// Imported by the RTL and by testbenches.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_XNOR = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_ROL  = 4'h8;
  localparam logic [3:0] OP_ROR  = 4'h9;
  localparam logic [3:0] OP_GT   = 4'hA;
  localparam logic [3:0] OP_EQ   = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_DIV  = 4'hD;
  localparam logic [3:0] OP_CLR  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  // Field order matches the 4-bit flags_q bus: {carry, overflow, zero, negative}.
  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: decodes the opcode and derives every flag
// from the operands and the final result.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   op_i,
  output logic [W-1:0] y_o,
  output flags_t       flags_o
);

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic [W-1:0]   y_d;
  logic           carry_d;
  logic           ovf_d;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
  // Guard the divider so a zero divisor yields a defined 0 rather than X.
  assign quot = (b_i == '0) ? '0 : (a_i / b_i);

  always_comb begin
    y_d     = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op_i)
      OP_ADD: begin
        y_d     = sum[W-1:0];
        carry_d = sum[W];
        ovf_d   = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      OP_SUB: begin
        y_d     = diff[W-1:0];
        carry_d = diff[W];
        ovf_d   = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
      end
      OP_AND:  y_d = a_i & b_i;
      OP_OR:   y_d = a_i | b_i;
      OP_XOR:  y_d = a_i ^ b_i;
      OP_XNOR: y_d = ~(a_i ^ b_i);
      OP_SLL: begin
        y_d     = {a_i[W-2:0], 1'b0};
        carry_d = a_i[W-1];
      end
      OP_SRL: begin
        y_d     = {1'b0, a_i[W-1:1]};
        carry_d = a_i[0];
      end
      OP_ROL: begin
        y_d     = {a_i[W-2:0], a_i[W-1]};
        carry_d = a_i[W-1];
      end
      OP_ROR: begin
        y_d     = {a_i[0], a_i[W-1:1]};
        carry_d = a_i[0];
      end
      OP_GT:  y_d = {{(W-1){1'b0}}, (a_i > b_i)};
      OP_EQ:  y_d = {{(W-1){1'b0}}, (a_i == b_i)};
      OP_MUL: begin
        y_d     = prod[W-1:0];
        carry_d = (prod[2*W-1:W] != '0);
        ovf_d   = (prod[2*W-1:W] != '0);
      end
      OP_DIV: begin
        y_d   = quot;
        ovf_d = (b_i == '0);
      end
      OP_CLR:  y_d = '0;
      OP_NOP:  y_d = a_i;
      default: y_d = '0;
    endcase
  end

  assign y_o              = y_d;
  assign flags_o.carry    = carry_d;
  assign flags_o.overflow = ovf_d;
  assign flags_o.zero     = (y_d == '0);
  assign flags_o.negative = y_d[W-1];

endmodule

// File: rtl/alu.sv
// W-bit ALU top: combinational result/flags straight from alu_core plus a
// one-cycle registered copy for pipelined consumers.
module alu
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   op,
  output logic [W-1:0] Y,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic [W-1:0] Y_q,
  output logic [3:0]   flags_q
);

  logic [W-1:0] y_d;
  flags_t       flags_d;

  alu_core #(.W(W)) u_core (
    .a_i     (A),
    .b_i     (B),
    .op_i    (op),
    .y_o     (y_d),
    .flags_o (flags_d)
  );

  assign Y        = y_d;
  assign carry    = flags_d.carry;
  assign overflow = flags_d.overflow;
  assign zero     = flags_d.zero;
  assign negative = flags_d.negative;

  // Reset wins over capture when both occur at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y_q     <= '0;
      flags_q <= '0;
    end else begin
      Y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed and randomised checks of the alu combinational and registered outputs
// against hand-computed vectors and a small arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic [3:0]   f;   // {carry, overflow, zero, negative}
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   op = OP_ADD;
  logic [W-1:0] Y;
  logic         carry, overflow, zero, negative;
  logic [W-1:0] Y_q;
  logic [3:0]   flags_q;

  int n_checks = 0;
  int n_fail   = 0;

  alu #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .op       (op),
    .Y        (Y),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative),
    .Y_q      (Y_q),
    .flags_q  (flags_q)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    // Inputs chosen so the combinational flags are nonzero while reset holds the register.
    @(negedge clk);
    rst = 1'b1; op = OP_ADD; A = 8'hFF; B = 8'h01;
    @(posedge clk); #1;
    n_checks++;
    if ({Y_q, flags_q} !== 12'h000) begin
      $display("FAIL reset_reg: got Y_q=%h flags_q=%b expected Y_q=00 flags_q=0000", Y_q, flags_q);
      n_fail++;
    end
    n_checks++;
    if ({Y, carry, overflow, zero, negative} !== {8'h00, 4'b1010}) begin
      $display("FAIL reset_comb: got Y=%h cvzn=%b%b%b%b expected Y=00 cvzn=1010",
               Y, carry, overflow, zero, negative);
      n_fail++;
    end
    $display("reset: Y_q=%h flags_q=%b Y=%h", Y_q, flags_q, Y);
  endtask

  task automatic test_arith();
    vec_t v[7] = '{
      '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010},
      '{OP_ADD, 8'h12, 8'h34, 8'h46, 4'b0000},
      '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101},
      '{OP_ADD, 8'h80, 8'h80, 8'h00, 4'b1110},
      '{OP_SUB, 8'h20, 8'h01, 8'h1F, 4'b0000},
      '{OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1001},
      '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0100}
    };
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      op = v[i].op; A = v[i].a; B = v[i].b;
      #1;
      n_checks++;
      if ({Y, carry, overflow, zero, negative} !== {v[i].y, v[i].f}) begin
        $display("FAIL arith[%0d]: got Y=%h cvzn=%b%b%b%b expected Y=%h cvzn=%b",
                 i, Y, carry, overflow, zero, negative, v[i].y, v[i].f);
        n_fail++;
      end
      $display("arith op=%h A=%h B=%h Y=%h cvzn=%b%b%b%b", op, A, B, Y, carry, overflow, zero, negative);
    end
  endtask

  task automatic test_logic();
    vec_t v[5] = '{
      '{OP_AND,  8'hAA, 8'h0F, 8'h0A, 4'b0000},
      '{OP_OR,   8'hA0, 8'h0F, 8'hAF, 4'b0001},
      '{OP_XOR,  8'hF0, 8'h0F, 8'hFF, 4'b0001},
      '{OP_XNOR, 8'hF0, 8'h0F, 8'h00, 4'b0010},
      '{OP_XNOR, 8'h3C, 8'h3C, 8'hFF, 4'b0001}
    };
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op = v[i].op; A = v[i].a; B = v[i].b;
      #1;
      n_checks++;
      if ({Y, carry, overflow, zero, negative} !== {v[i].y, v[i].f}) begin
        $display("FAIL logic[%0d]: got Y=%h cvzn=%b%b%b%b expected Y=%h cvzn=%b",
                 i, Y, carry, overflow, zero, negative, v[i].y, v[i].f);
        n_fail++;
      end
      $display("logic op=%h A=%h B=%h Y=%h cvzn=%b%b%b%b", op, A, B, Y, carry, overflow, zero, negative);
    end
  endtask

  task automatic test_shift();
    // B is deliberately nonzero: shifts must ignore it.
    vec_t v[6] = '{
      '{OP_SLL, 8'h81, 8'hFF, 8'h02, 4'b1000},
      '{OP_SRL, 8'h81, 8'hFF, 8'h40, 4'b1000},
      '{OP_ROL, 8'h81, 8'hFF, 8'h03, 4'b1000},
      '{OP_ROR, 8'h81, 8'hFF, 8'hC0, 4'b1001},
      '{OP_SLL, 8'h40, 8'h00, 8'h80, 4'b0001},
      '{OP_SRL, 8'h01, 8'h00, 8'h00, 4'b1010}
    };
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      op = v[i].op; A = v[i].a; B = v[i].b;
      #1;
      n_checks++;
      if ({Y, carry, overflow, zero, negative} !== {v[i].y, v[i].f}) begin
        $display("FAIL shift[%0d]: got Y=%h cvzn=%b%b%b%b expected Y=%h cvzn=%b",
                 i, Y, carry, overflow, zero, negative, v[i].y, v[i].f);
        n_fail++;
      end
      $display("shift op=%h A=%h B=%h Y=%h cvzn=%b%b%b%b", op, A, B, Y, carry, overflow, zero, negative);
    end
  endtask

  task automatic test_misc();
    vec_t v[14] = '{
      '{OP_GT,  8'h05, 8'h03, 8'h01, 4'b0000},
      '{OP_GT,  8'h03, 8'h05, 8'h00, 4'b0010},
      '{OP_GT,  8'h80, 8'h7F, 8'h01, 4'b0000},
      '{OP_EQ,  8'h09, 8'h09, 8'h01, 4'b0000},
      '{OP_EQ,  8'h09, 8'h08, 8'h00, 4'b0010},
      '{OP_MUL, 8'h0F, 8'h03, 8'h2D, 4'b0000},
      '{OP_MUL, 8'h10, 8'h10, 8'h00, 4'b1110},
      '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 4'b1100},
      '{OP_DIV, 8'h14, 8'h04, 8'h05, 4'b0000},
      '{OP_DIV, 8'h07, 8'h00, 8'h00, 4'b0110},
      '{OP_DIV, 8'hFF, 8'h02, 8'h7F, 4'b0000},
      '{OP_CLR, 8'hA5, 8'h5A, 8'h00, 4'b0010},
      '{OP_NOP, 8'hA5, 8'h5A, 8'hA5, 4'b0001},
      '{OP_NOP, 8'h00, 8'hFF, 8'h00, 4'b0010}
    };
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      op = v[i].op; A = v[i].a; B = v[i].b;
      #1;
      n_checks++;
      if ({Y, carry, overflow, zero, negative} !== {v[i].y, v[i].f}) begin
        $display("FAIL misc[%0d]: got Y=%h cvzn=%b%b%b%b expected Y=%h cvzn=%b",
                 i, Y, carry, overflow, zero, negative, v[i].y, v[i].f);
        n_fail++;
      end
      $display("misc op=%h A=%h B=%h Y=%h cvzn=%b%b%b%b", op, A, B, Y, carry, overflow, zero, negative);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[4] = '{
      '{OP_ADD, 8'h12, 8'h34, 8'h46, 4'b0000},
      '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101},
      '{OP_DIV, 8'h07, 8'h00, 8'h00, 4'b0110},
      '{OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1001}
    };
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op = v[i].op; A = v[i].a; B = v[i].b;
      @(posedge clk); #1;
      n_checks++;
      if ({Y_q, flags_q} !== {v[i].y, v[i].f}) begin
        $display("FAIL reg[%0d]: got Y_q=%h flags_q=%b expected Y_q=%h flags_q=%b",
                 i, Y_q, flags_q, v[i].y, v[i].f);
        n_fail++;
      end
      $display("reg op=%h A=%h B=%h Y_q=%h flags_q=%b", op, A, B, Y_q, flags_q);
    end
    // Reset asserted while a non-zero result is presented: reset must win.
    @(negedge clk);
    op = OP_ADD; A = 8'h7F; B = 8'h01; rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({Y_q, flags_q} !== 12'h000) begin
      $display("FAIL reg_reset: got Y_q=%h flags_q=%b expected Y_q=00 flags_q=0000", Y_q, flags_q);
      n_fail++;
    end
    n_checks++;
    if (Y !== 8'h80) begin
      $display("FAIL reg_reset_comb: got Y=%h expected Y=80", Y);
      n_fail++;
    end
    $display("reg reset: Y_q=%h flags_q=%b Y=%h", Y_q, flags_q, Y);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] ey;
    logic         ec, ev;
    int           ua, s, sa, sb;
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      op = 4'($urandom_range(0, 5));
      A  = W'($urandom);
      B  = W'($urandom);
      sa = int'($signed(A));
      sb = int'($signed(B));
      ec = 1'b0; ev = 1'b0; ey = '0;
      case (op)
        OP_ADD: begin
          ua = int'(A) + int'(B); ey = ua[W-1:0]; ec = (ua > 255);
          s  = sa + sb; ev = (s > 127) || (s < -128);
        end
        OP_SUB: begin
          ua = int'(A) - int'(B); ey = ua[W-1:0]; ec = (A < B);
          s  = sa - sb; ev = (s > 127) || (s < -128);
        end
        OP_AND:  ey = A & B;
        OP_OR:   ey = A | B;
        OP_XOR:  ey = A ^ B;
        default: ey = ~(A ^ B);
      endcase
      #1;
      n_checks++;
      if ({Y, carry, overflow, zero, negative} !== {ey, ec, ev, (ey == '0), ey[W-1]}) begin
        $display("FAIL random[%0d]: op=%h A=%h B=%h got Y=%h cvzn=%b%b%b%b expected Y=%h cvzn=%b%b%b%b",
                 i, op, A, B, Y, carry, overflow, zero, negative, ey, ec, ev, (ey == '0), ey[W-1]);
        n_fail++;
      end
      $display("random op=%h A=%h B=%h Y=%h", op, A, B, Y);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_misc();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
